// File: rtl/seg7_pkg.sv
// Shared types and seven-segment constants for the push-button BCD counter.
// Segment bytes are active-low with bit0 = decimal point (always off).
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry [n] is the segment byte for decimal digit n.
    localparam logic [9:0][7:0] SEG_TABLE = {
        8'h19, 8'h01, 8'h1F, 8'hC1, 8'h49,
        8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
    };

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_INC,
        CMD_DEC,
        CMD_CLR,
        CMD_NOP
    } cmd_e;

    function automatic logic [7:0] seg7_encode(input logic [3:0] d);
        if (d <= 4'd9) begin
            return SEG_TABLE[d];
        end
        return SEG_BLANK;
    endfunction

    // Button [3] is not wired to any function, so only [2:0] are decoded.
    function automatic cmd_e decode_btn(input logic [2:0] b);
        case (b)
            3'b110:  return CMD_INC;
            3'b101:  return CMD_DEC;
            3'b011:  return CMD_CLR;
            3'b111:  return CMD_NONE;
            default: return CMD_NOP;
        endcase
    endfunction

endpackage

// File: rtl/bcd_updown_digit.sv
// One registered BCD digit. Increment/decrement requests ripple in from the
// lower digit; carry/borrow out are combinational so a whole chain settles in one cycle.
module bcd_updown_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc_in,
    input  logic       dec_in,
    output logic       inc_out,
    output logic       dec_out,
    output logic [3:0] digit
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        inc_out = 1'b0;
        dec_out = 1'b0;
        if (clr) begin
            digit_d = 4'd0;
        end else if (inc_in) begin
            if (digit_q >= 4'd9) begin
                digit_d = 4'd0;
                inc_out = 1'b1;
            end else begin
                digit_d = digit_q + 4'd1;
            end
        end else if (dec_in) begin
            if (digit_q == 4'd0) begin
                digit_d = 4'd9;
                dec_out = 1'b1;
            end else begin
                digit_d = digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/btn_bcd_counter_disp.sv
// Push-button BCD up/down counter with tick-rate debounce, auto-repeat and
// static seven-segment output. Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module btn_bcd_counter_disp
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int TICK_DIV     = 8388608,
    parameter int REPEAT_DELAY = 5,
    parameter int WRAP         = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [3:0]            btn,
    output logic [4*DIGITS-1:0]   value_bcd,
    output logic [8*DIGITS-1:0]   seg,
    output logic                  step
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [8*DIGITS-1:0] SEG_RST =
        ({DIGITS{SEG_BLANK}} << 8) | (8*DIGITS)'(SEG_TABLE[0]);
`else
    localparam logic [8*DIGITS-1:0] SEG_RST = {DIGITS{SEG_TABLE[0]}};
`endif

    logic [3:0]          sync1_q, sync1_d;
    logic [3:0]          sync2_q, sync2_d;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic                tick;
    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0]   hold_inc;
    cmd_e                cmd;
    logic                exec;
    logic                all_nine, all_zero;
    logic                do_inc, do_dec, do_clr;
    logic                step_q, step_d;
    logic [8*DIGITS-1:0] seg_q, seg_d;
    logic                unused_bits;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
    end

    always_comb begin
        tick       = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    end

    assign cmd = decode_btn(sync2_q[2:0]);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        hold_inc   = hold_cnt_q + HOLD_W'(1);
        exec       = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (cmd != CMD_NONE) begin
                        exec       = 1'b1;
                        hold_cnt_d = '0;
                        state_d    = HOLD;
                    end
                end
                HOLD: begin
                    if (cmd == CMD_NONE) begin
                        state_d = IDLE;
                    end else begin
                        hold_cnt_d = hold_inc;
                        if (hold_inc == HOLD_W'(REPEAT_DELAY)) begin
                            state_d = REPEAT;
                        end
                    end
                end
                REPEAT: begin
                    // The live command is used, so switching buttons mid-hold takes effect at once.
                    if (cmd == CMD_NONE) begin
                        state_d = IDLE;
                    end else begin
                        exec = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign all_nine = (value_bcd == {DIGITS{4'h9}});
    assign all_zero = (value_bcd == '0);

    always_comb begin
        do_inc = exec && (cmd == CMD_INC) && ((WRAP != 0) || !all_nine);
        do_dec = exec && (cmd == CMD_DEC) && ((WRAP != 0) || !all_zero);
        do_clr = exec && (cmd == CMD_CLR);
        step_d = do_inc || do_dec || (do_clr && !all_zero);
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic c_in, b_in, c_out, b_out;
        if (i == 0) begin : g_first
            assign c_in = do_inc;
            assign b_in = do_dec;
        end else begin : g_next
            assign c_in = g_digit[i-1].c_out;
            assign b_in = g_digit[i-1].b_out;
        end
        bcd_updown_digit u_digit (
            .clk     (CLK),
            .rst     (RST),
            .clr     (do_clr),
            .inc_in  (c_in),
            .dec_in  (b_in),
            .inc_out (c_out),
            .dec_out (b_out),
            .digit   (value_bcd[4*i +: 4])
        );
    end

    // The top carry/borrow wrap naturally; saturation is gated before the chain.
    assign unused_bits = sync2_q[3] ^ g_digit[DIGITS-1].c_out ^ g_digit[DIGITS-1].b_out;

`ifdef LEADING_ZERO_BLANK_EN
    logic       lead;
    logic [3:0] dig;
    always_comb begin
        seg_d = '0;
        lead  = 1'b1;
        dig   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig = value_bcd[4*i +: 4];
            if (lead && (dig == 4'd0) && (i != 0)) begin
                seg_d[8*i +: 8] = SEG_BLANK;
            end else begin
                lead            = 1'b0;
                seg_d[8*i +: 8] = seg7_encode(dig);
            end
        end
    end
`else
    always_comb begin
        seg_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg_d[8*i +: 8] = seg7_encode(value_bcd[4*i +: 4]);
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q    <= 4'b1111;
            sync2_q    <= 4'b1111;
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            step_q     <= 1'b0;
            seg_q      <= SEG_RST;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            step_q     <= step_d;
            seg_q      <= seg_d;
        end
    end

    assign step = step_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_btn_bcd_counter_disp.sv
// Bench for btn_bcd_counter_disp: wrapping and saturating instances share stimulus;
// per-tick scoreboard against an integer reference plus a table of row end-states.
module tb_btn_bcd_counter_disp;

    localparam int DIGITS = 4;
    localparam int TDIV   = 4;
    localparam int RD     = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  btn = 4'b1111;
    logic [15:0] val_w, val_s;
    logic [31:0] seg_w, seg_s;
    logic        step_w, step_s;

    always #5 CLK = ~CLK;

    btn_bcd_counter_disp #(.DIGITS(DIGITS), .TICK_DIV(TDIV), .REPEAT_DELAY(RD), .WRAP(1)) dut_w (
        .CLK(CLK), .RST(RST), .btn(btn), .value_bcd(val_w), .seg(seg_w), .step(step_w));

    btn_bcd_counter_disp #(.DIGITS(DIGITS), .TICK_DIV(TDIV), .REPEAT_DELAY(RD), .WRAP(0)) dut_s (
        .CLK(CLK), .RST(RST), .btn(btn), .value_bcd(val_s), .seg(seg_s), .step(step_s));

    localparam logic [7:0] SEGS [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                         8'h49, 8'hC1, 8'h1F, 8'h01, 8'h19};

    typedef struct {
        logic [15:0] w;
        logic [15:0] s;
        logic        sw;
        logic        ss;
    } exp_t;

    typedef struct {
        logic [3:0]  b;
        int          n;
        logic [15:0] ew;
        logic [15:0] es;
        int          stw;
        int          sts;
    } row_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   since  = 0;
    int   m_w, m_s, m_hold, m_state;
    int   stp_w = 0;
    int   stp_s = 0;

    always @(negedge CLK) begin
        if (step_w) stp_w <= stp_w + 1;
        if (step_s) stp_s <= stp_s + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] seg_of(input int v);
        logic [31:0] r;
        int x, shown;
        r = '0;
        x = v;
        shown = 4;
`ifdef LEADING_ZERO_BLANK_EN
        shown = (v >= 1000) ? 4 : (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
`endif
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = (k < shown) ? SEGS[x % 10] : 8'hFF;
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_w = 0; m_s = 0; m_hold = 0; m_state = 0;
    endtask

    task automatic model_tick(input logic [3:0] b);
        int   cmd, pw, ps;
        bit   ex;
        exp_t e;
        ex = 1'b0;
        case (b[2:0])
            3'b110:  cmd = 1;
            3'b101:  cmd = 2;
            3'b011:  cmd = 3;
            3'b111:  cmd = 0;
            default: cmd = 4;
        endcase
        case (m_state)
            0: if (cmd != 0) begin ex = 1'b1; m_hold = 0; m_state = 1; end
            1: if (cmd == 0) m_state = 0;
               else begin m_hold++; if (m_hold == RD) m_state = 2; end
            default: if (cmd == 0) m_state = 0; else ex = 1'b1;
        endcase
        pw = m_w;
        ps = m_s;
        if (ex) begin
            case (cmd)
                1: begin m_w = (m_w + 1) % 10000; m_s = (m_s == 9999) ? 9999 : m_s + 1; end
                2: begin m_w = (m_w + 9999) % 10000; m_s = (m_s == 0) ? 0 : m_s - 1; end
                3: begin m_w = 0; m_s = 0; end
                default: ;
            endcase
        end
        e.w  = to_bcd(m_w);
        e.s  = to_bcd(m_s);
        e.sw = (m_w != pw);
        e.ss = (m_s != ps);
        sb_q.push_back(e);
    endtask

    task automatic next_tick();
        exp_t e;
        model_tick(btn);
        repeat (TDIV - since) @(posedge CLK);
        #1;
        since = 0;
        e = sb_q.pop_front();
        check("tick_val_w", 32'(val_w), 32'(e.w));
        check("tick_val_s", 32'(val_s), 32'(e.s));
        check("tick_step_w", 32'(step_w), 32'(e.sw));
        check("tick_step_s", 32'(step_s), 32'(e.ss));
    endtask

    task automatic one_clk();
        @(posedge CLK);
        #1;
        since++;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        since = 0;
        model_reset();
        check("rst_val_w", 32'(val_w), 32'h0);
        check("rst_val_s", 32'(val_s), 32'h0);
        check("rst_seg_w", seg_w, seg_of(0));
        check("rst_seg_s", seg_s, seg_of(0));
        check("rst_step_w", 32'(step_w), 32'h0);
        check("rst_step_s", 32'(step_s), 32'h0);
    endtask

    row_t rows [28];

    initial begin
        int sw0, ss0;
        rows = '{
            '{4'b1111,    20, 16'h0000, 16'h0000,     0,    0},
            '{4'b1110,     1, 16'h0001, 16'h0001,     1,    1},
            '{4'b1111,     2, 16'h0001, 16'h0001,     0,    0},
            '{4'b1011,     1, 16'h0000, 16'h0000,     1,    1},
            '{4'b1111,     1, 16'h0000, 16'h0000,     0,    0},
            '{4'b1110,    10, 16'h0007, 16'h0007,     7,    7},
            '{4'b1111,     1, 16'h0007, 16'h0007,     0,    0},
            '{4'b1100,     6, 16'h0007, 16'h0007,     0,    0},
            '{4'b1111,     1, 16'h0007, 16'h0007,     0,    0},
            '{4'b1110,    38, 16'h0042, 16'h0042,    35,   35},
            '{4'b1111,     1, 16'h0042, 16'h0042,     0,    0},
            '{4'b1011,     1, 16'h0000, 16'h0000,     1,    1},
            '{4'b1111,     1, 16'h0000, 16'h0000,     0,    0},
            '{4'b1011,     1, 16'h0000, 16'h0000,     0,    0},
            '{4'b1111,     1, 16'h0000, 16'h0000,     0,    0},
            '{4'b1101,     1, 16'h9999, 16'h0000,     1,    0},
            '{4'b1111,     1, 16'h9999, 16'h0000,     0,    0},
            '{4'b1110,     1, 16'h0000, 16'h0001,     1,    1},
            '{4'b1111,     1, 16'h0000, 16'h0001,     0,    0},
            '{4'b1110,     5, 16'h0002, 16'h0003,     2,    2},
            '{4'b1101,     3, 16'h9999, 16'h0000,     3,    3},
            '{4'b1111,     1, 16'h9999, 16'h0000,     0,    0},
            '{4'b1101,     1, 16'h9998, 16'h0000,     1,    0},
            '{4'b1111,     1, 16'h9998, 16'h0000,     0,    0},
            '{4'b1110, 10007, 16'h0002, 16'h9999, 10004, 9999},
            '{4'b1111,     1, 16'h0002, 16'h9999,     0,    0},
            '{4'b1110,     1, 16'h0003, 16'h9999,     1,    0},
            '{4'b1111,     1, 16'h0003, 16'h9999,     0,    0}
        };

        do_reset();

        for (int r = 0; r < 28; r++) begin
            btn = rows[r].b;
            sw0 = stp_w;
            ss0 = stp_s;
            for (int t = 0; t < rows[r].n; t++) begin
                next_tick();
            end
            check($sformatf("row%0d_val_w", r), 32'(val_w), 32'(rows[r].ew));
            check($sformatf("row%0d_val_s", r), 32'(val_s), 32'(rows[r].es));
            one_clk();
            check($sformatf("row%0d_steps_w", r), 32'(stp_w - sw0), 32'(rows[r].stw));
            check($sformatf("row%0d_steps_s", r), 32'(stp_s - ss0), 32'(rows[r].sts));
            check($sformatf("row%0d_seg_w", r), seg_w, seg_of(m_w));
            check($sformatf("row%0d_seg_s", r), seg_s, seg_of(m_s));
        end

        // Reset while auto-repeating with INC still held.
        btn = 4'b1110;
        for (int t = 0; t < 6; t++) begin
            next_tick();
        end
        check("pre_rst_val_w", 32'(val_w), 32'h0006);
        do_reset();
        next_tick();
        check("post_rst_val_w", 32'(val_w), 32'h0001);
        check("post_rst_step_w", 32'(step_w), 32'h1);
        one_clk();
`ifdef LEADING_ZERO_BLANK_EN
        check("post_rst_seg_w", seg_w, 32'hFFFFFF9F);
`else
        check("post_rst_seg_w", seg_w, 32'h0303039F);
`endif
        for (int t = 0; t < 3; t++) begin
            next_tick();
        end
        check("post_rst_hold_w", 32'(val_w), 32'h0001);
        btn = 4'b1111;
        next_tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
